// File: rtl/uart_txfun.sv
// UART transmitter: accepts one byte over a valid/ready handshake and sends
// start bit, LSB-first data, optional parity and 1 or 2 stop bits on tx_pin.
module uart_txfun #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin,
    output logic       tx_busy
);

    localparam int              CPB       = (CLK_FRE * 1_000_000) / BAUD_RATE;
    localparam int              CW        = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CPB - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic            ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   pin_q, pin_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;

        // The baud counter free-runs through every bit of a frame and wraps
        // at each bit boundary; it stays parked at zero while idle.
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_data_valid && ready_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = tx_data[DATA_BITS-1:0];
                    par_d   = (^tx_data[DATA_BITS-1:0]) ^ ODD_MODE;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop in the
    // same cycle the state register changes.
    always_comb begin
        pin_d   = 1'b1;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  pin_d = 1'b0;
            ST_DATA:   pin_d = shift_d[0];
            ST_PARITY: pin_d = par_d;
            default:   pin_d = 1'b1;
        endcase
    end

    assign tx_pin        = pin_q;
    assign tx_data_ready = ready_q;
    assign tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_txfun.sv
// Bench for uart_txfun: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop) at 4 clocks per bit, checked cycle by cycle against a frame model.
module tb_uart_txfun;

    localparam int CPB = 4;

    logic       clock  = 1'b0;
    logic       nreset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] valid = 3'b000;
    logic [2:0] ready;
    logic [2:0] pin;
    logic [2:0] busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    uart_txfun #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clock(clock), .nreset(nreset), .tx_data(tx_data), .tx_data_valid(valid[0]),
        .tx_data_ready(ready[0]), .tx_pin(pin[0]), .tx_busy(busy[0]));

    uart_txfun #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clock(clock), .nreset(nreset), .tx_data(tx_data), .tx_data_valid(valid[1]),
        .tx_data_ready(ready[1]), .tx_pin(pin[1]), .tx_busy(busy[1]));

    uart_txfun #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_odd2 (
        .clock(clock), .nreset(nreset), .tx_data(tx_data), .tx_data_valid(valid[2]),
        .tx_data_ready(ready[2]), .tx_pin(pin[2]), .tx_busy(busy[2]));

    function automatic int par_mode(int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 1;
    endfunction

    function automatic int stop_n(int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(int k);
        return (1 + 8 + ((par_mode(k) != 0) ? 1 : 0) + stop_n(k)) * CPB;
    endfunction

    // Expected line level at cycle c of a frame (c = 0 is the first start-bit cycle).
    function automatic logic exp_level(int k, logic [7:0] b, int c);
        int bitn;
        bitn = c / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
        if (par_mode(k) != 0 && bitn == 9) return (^b) ^ (par_mode(k) == 1);
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(int cycles, string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check(tag, {23'd0, pin, ready, busy}, {23'd0, 9'b111_111_000});
        end
    endtask

    // Present byte b to instance k, wait for the transfer and check the whole
    // frame. keep: leave valid high afterwards; gap: a frame has just ended
    // with valid held, so ready must be seen on the very next cycle.
    task automatic send(int k, logic [7:0] b, bit keep, bit gap, bit pulse);
        int n;
        int len;
        logic [7:0] dec;
        n   = 0;
        len = frame_len(k);
        dec = 8'h00;
        @(negedge clock);
        tx_data  = b;
        valid[k] = 1'b1;
        while (!ready[k] && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (gap) check("gap_ready", n, 0);
        if (!ready[k]) begin
            check("ready_timeout", 0, 1);
            valid[k] = 1'b0;
            return;
        end
        check("pre_start_pin", pin[k], 1);
        @(posedge clock);
        for (int c = 0; c < len; c++) begin
            @(negedge clock);
            if (c == 0 && !keep) valid[k] = 1'b0;
            if (c == 1) tx_data = ~b;
            if (pulse && c == 12) begin
                valid[k] = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulse && c == 13) valid[k] = 1'b0;
            check("pin", pin[k], exp_level(k, b, c));
            check("ready_low", ready[k], 0);
            check("busy_high", busy[k], 1);
            if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) dec[c / CPB - 1] = pin[k];
        end
        check("decode", dec, b);
        $display("frame inst=%0d data=%02h len=%0d decoded=%02h", k, b, len, dec);
    endtask

    // Start a frame, then assert reset between clock edges at frame cycle cyc.
    task automatic abort_at(int k, logic [7:0] b, int cyc);
        @(negedge clock);
        check("abort_start_ready", ready[k], 1);
        tx_data  = b;
        valid[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid[k] = 1'b0;
        repeat (cyc) @(negedge clock);
        check("pre_abort_pin", pin[k], exp_level(k, b, cyc));
        check("pre_abort_busy", busy[k], 1);
        #2 nreset = 1'b0;
        #1;
        check("abort_pin", pin[k], 1);
        check("abort_busy", busy[k], 0);
        check("abort_ready", ready[k], 1);
        repeat (3) @(negedge clock);
        nreset = 1'b1;
        check_idle(20, "post_abort_idle");
        $display("abort inst=%0d data=%02h at_cycle=%0d", k, b, cyc);
    endtask

    initial begin
        logic [7:0] b1;
        logic [7:0] b2;
        int k;

        #1 nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_state", {23'd0, pin, ready, busy}, {23'd0, 9'b111_111_000});
        end
        nreset = 1'b1;
        check_idle(20, "post_reset_idle");
        $display("reset released, line idle");

        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        check_idle(2, "idle_after_55");
        send(1, 8'h07, 1'b0, 1'b0, 1'b0);
        check_idle(2, "idle_after_even");
        send(2, 8'h07, 1'b0, 1'b0, 1'b0);
        check_idle(2, "idle_after_odd");

        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
        check_idle(2, "idle_after_b2b");

        send(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_idle(20, "no_second_frame");

        abort_at(0, 8'h0F, 17);
        abort_at(1, 8'h81, 2);

        send(0, 8'h81, 1'b0, 1'b0, 1'b0);
        check_idle(1, "idle_after_81");
        send(2, 8'h81, 1'b0, 1'b0, 1'b0);
        check_idle(1, "idle_after_81_2stop");

        for (int i = 0; i < 30; i++) begin
            k  = int'($urandom_range(0, 2));
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                send(k, b1, 1'b1, 1'b0, 1'b0);
                send(k, b2, 1'b0, 1'b1, 1'b0);
            end else begin
                send(k, b1, 1'b0, 1'b0, 1'b0);
            end
            check_idle(1, "idle_after_random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
